bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//  Parallel-to-serial front end for the sequence checker. Accepts a WIDTH-bit word
//  through a valid/ready handshake and shifts it out one bit per clk on x, which
//  drives the checker's serial input directly.
//  Frames are emitted back-to-back with no idle gap when words arrive in time.
// PARAMETERS
//  WIDTH      8   data word width; legal range 2..32
//  MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  clk         in   1      single clock; all flops update on its rising edge
//  reset       in   1      asynchronous, active-low reset (0 = reset)
//  load_data   in   WIDTH  parallel word to serialize
//  load_valid  in   1      load_data is valid
//  load_ready  out  1      serializer can take a word this cycle (combinational)
//  x           out  1      serial data bit, registered
//  x_valid     out  1      x carries a frame bit this cycle, registered
//  busy        out  1      a frame is in progress, registered
//  frame_done  out  1      one-cycle pulse, high during the last bit of a frame
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; x=0; x_valid=0; busy=0; frame_done=0;
//    shift register and bit counter cleared. load_ready is 0 while reset is asserted.
//  - Handshake: a word is accepted on the rising edge where load_valid && load_ready.
//    load_data is sampled only at that edge. While load_ready=0, load_valid is ignored
//    and the word is not lost. The source must hold load_valid and load_data stable.
//  - load_ready = (state==IDLE) || (last bit cycle && no parity bit pending).
//  - Latency: for a word accepted at edge N, its first bit is on x with x_valid=1
//    in the cycle after edge N. Bit k is on x in cycle N+1+k.
//  - FSM states:
//    IDLE  -> SHIFT on accept.
//    SHIFT -> (last bit) PARITY if SER_PARITY_EN is defined.
//    SHIFT -> (last bit) SHIFT if a new word is accepted in the same cycle.
//    SHIFT -> (last bit) IDLE otherwise.
//    PARITY -> SHIFT on accept, else IDLE.
//  - Bit counter: $clog2(WIDTH) bits; counts 0..WIDTH-1; the last bit is cnt==WIDTH-1.
//    The counter reloads to 0 on accept and has no wrap beyond WIDTH-1.
//  - In IDLE: x=0, x_valid=0, busy=0.
//  - busy=1 in SHIFT and PARITY.
//  - frame_done=1 coincident with the final emitted bit: the data bit, or the parity
//    bit when SER_PARITY_EN is defined.
//  - Simultaneous last bit and accept: the new word's first bit follows with no gap.
//    frame_done still pulses for the old frame.
//  - Reset asserted mid-frame: the frame is abandoned immediately and x_valid drops
//    asynchronously. No partial-frame frame_done is produced.
// CONFIGURATION
//  SER_PARITY_EN defined:
//    - One even-parity bit (^word) is appended after the WIDTH data bits, with x_valid=1.
//    - A frame is WIDTH+1 cycles long.
//    - load_ready in the frame's final cycle applies during the PARITY cycle, not the
//      last data bit.
//  SER_PARITY_EN undefined:
//    - The PARITY state and the parity flop are absent.
//    - A frame is exactly WIDTH cycles long.
// STRUCTURE
//  - Package ser_pkg: state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1,
//    ST_PARITY=2'd2, and a function for counter width ($clog2 wrapper).
//  - One sub-module is natural: ser_bit_counter. It is a loadable 0..WIDTH-1 counter
//    with a last_bit output.
//  - The shift register, FSM and output flops stay in bit_serializer.
// TESTING (WIDTH=8 unless noted)
//  1. Reset, then load 8'hB3 once.
//     -> x = 1,0,1,1,0,0,1,1 in cycles N+1..N+8; x_valid high for those 8 cycles;
//        frame_done in cycle N+8; then IDLE.
//  2. Back-to-back: 8'hFF with load_valid held, then 8'h00 offered during the last bit.
//     -> 16 contiguous x_valid cycles, x = 8 ones then 8 zeros;
//        frame_done in cycles N+8 and N+16.
//  3. load_valid=1 with 8'h5A while busy mid-frame.
//     -> no accept until load_ready; 8'h5A is sent intact afterwards.
//  4. reset=0 at bit 3 of 8'hC3.
//     -> x=0, x_valid=0, busy=0 immediately; after release, load_ready=1 and
//        no stray bits.
//  5. MSB_FIRST=0, load 8'h01.
//     -> x = 1,0,0,0,0,0,0,0.
//  6. SER_PARITY_EN defined, load 8'hB3 (five ones).
//     -> 9th bit x=1 with x_valid=1; frame_done in cycle N+9.
//     8'h03 -> 9th bit x=0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: state encoding and counter sizing.
package ser_pkg;

  // Serializer FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } ser_state_e;

  // Bit-counter width for a given word width (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable 0..WIDTH-1 bit counter; tracks which data bit is currently on x.
// Saturates at WIDTH-1; flags the last and second-to-last positions.
module ser_bit_counter
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic last_o,
  output logic penult_o
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o   = (cnt_q == CW'(WIDTH - 1));
  assign penult_o = (cnt_q == CW'(WIDTH - 2));

  // Next count: reload on accept, otherwise step until the last bit
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !last_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word over valid/ready and
// shifts it out one bit per clock on x, back-to-back when words arrive in time.
// Optional feature macro: SER_PARITY_EN appends one even-parity bit per frame.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             busy_q, busy_d;
  logic             fd_q, fd_d;
  logic             accept;
  logic             cnt_load;
  logic             cnt_en;
  logic             last_bit;
  logic             penult_bit;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  ser_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (cnt_load),
    .en_i    (cnt_en),
    .last_o  (last_bit),
    .penult_o(penult_bit)
  );

  // Ready in idle or in the final cycle of a frame; never while in reset
`ifdef SER_PARITY_EN
  assign load_ready = reset && ((state_q == ST_IDLE) || (state_q == ST_PARITY));
`else
  assign load_ready = reset && ((state_q == ST_IDLE) ||
                                ((state_q == ST_SHIFT) && last_bit));
`endif

  assign accept = load_valid && load_ready;

  // Next state, shift register and next output values
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    x_d      = 1'b0;
    fd_d     = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
`ifdef SER_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          cnt_en = 1'b1;
        end else begin
`ifdef SER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
      ST_PARITY: begin
        state_d = accept ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      // First bit goes straight to x; the remainder waits in the shift register
      cnt_load = 1'b1;
      x_d      = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
      sreg_d   = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
`ifdef SER_PARITY_EN
      par_d    = ^load_data;
`endif
    end else if (state_d == ST_SHIFT) begin
      x_d    = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
      sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
`ifndef SER_PARITY_EN
      fd_d   = penult_bit;
`endif
    end
`ifdef SER_PARITY_EN
    else if (state_d == ST_PARITY) begin
      x_d  = par_q;
      fd_d = 1'b1;
    end
`endif

    xv_d   = (state_d != ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign x          = x_q;
  assign x_valid    = xv_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (MSB-first and LSB-first) share the
// stimulus; a queue-based frame model predicts every output each cycle.
module tb_bit_serializer;

  localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
  localparam int unsigned FLEN = W + 1;
  localparam bit          PAR  = 1'b1;
`else
  localparam int unsigned FLEN = W;
  localparam bit          PAR  = 1'b0;
`endif
  localparam int unsigned OBS_N = 2048;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;

  logic m_ready, m_x, m_v, m_busy, m_fd;
  logic l_ready, l_x, l_v, l_busy, l_fd;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(m_ready), .x(m_x), .x_valid(m_v), .busy(m_busy), .frame_done(m_fd)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(l_ready), .x(l_x), .x_valid(l_v), .busy(l_busy), .frame_done(l_fd)
  );

  // Model: one queue entry per upcoming emitted bit; the head is what x shows now
  typedef struct packed {
    logic b;
    logic last;
  } ebit_t;

  ebit_t q_m[$];
  ebit_t q_l[$];

  typedef struct packed {
    logic [7:0] word;
    logic [7:0] seq_m;  // emitted order, first bit in [7], MSB-first instance
    logic [7:0] seq_l;  // emitted order, first bit in [7], LSB-first instance
    logic       par;
  } vec_t;

  vec_t vecs[10];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   last_acc = 1'b0;
  logic obs_x[OBS_N];
  logic obs_xl[OBS_N];
  logic obs_v[OBS_N];
  logic obs_fd[OBS_N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    for (int i = 0; i < int'(W); i++) begin
      q_m.push_back('{b: w[W-1-i], last: (i == int'(W) - 1) && !PAR});
      q_l.push_back('{b: w[i],     last: (i == int'(W) - 1) && !PAR});
    end
    if (PAR) begin
      q_m.push_back('{b: ^w, last: 1'b1});
      q_l.push_back('{b: ^w, last: 1'b1});
    end
  endtask

  task automatic check_outputs();
    chk("m_x",     m_x,     (q_m.size() > 0) ? q_m[0].b : 1'b0);
    chk("m_valid", m_v,     q_m.size() > 0);
    chk("m_busy",  m_busy,  q_m.size() > 0);
    chk("m_done",  m_fd,    (q_m.size() > 0) ? q_m[0].last : 1'b0);
    chk("m_ready", m_ready, reset && (q_m.size() <= 1));
    chk("l_x",     l_x,     (q_l.size() > 0) ? q_l[0].b : 1'b0);
    chk("l_valid", l_v,     q_l.size() > 0);
    chk("l_done",  l_fd,    (q_l.size() > 0) ? q_l[0].last : 1'b0);
    chk("l_ready", l_ready, reset && (q_l.size() <= 1));
  endtask

  // One clock: advance the model at the rising edge, check at the falling edge
  task automatic step();
    bit acc;
    @(posedge clk);
    acc = load_valid && reset && (q_m.size() <= 1);
    if (q_m.size() > 0) void'(q_m.pop_front());
    if (q_l.size() > 0) void'(q_l.pop_front());
    if (acc) push_frame(load_data);
    last_acc = acc;
    @(negedge clk);
    cyc++;
    check_outputs();
    if (cyc < int'(OBS_N)) begin
      obs_x[cyc]  = m_x;
      obs_xl[cyc] = l_x;
      obs_v[cyc]  = m_v;
      obs_fd[cyc] = m_fd;
    end
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    last_acc = 1'b0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 40);
    chk(name, last_acc, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q_m.size() > 0 && n < 40) begin
      step();
      n++;
    end
    chk("idle_reached", q_m.size(), 0);
  endtask

  function automatic logic [7:0] grab_m(input int s);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[7-k] = obs_x[s+k];
    return r;
  endfunction

  function automatic logic [7:0] grab_l(input int s);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[7-k] = obs_xl[s+k];
    return r;
  endfunction

  initial begin
    int start;
    int cnt_v;
    int cnt_fd;
    logic [15:0] two;

    vecs[0] = '{word: 8'hB3, seq_m: 8'hB3, seq_l: 8'hCD, par: 1'b1};
    vecs[1] = '{word: 8'h01, seq_m: 8'h01, seq_l: 8'h80, par: 1'b1};
    vecs[2] = '{word: 8'h5A, seq_m: 8'h5A, seq_l: 8'h5A, par: 1'b0};
    vecs[3] = '{word: 8'hC3, seq_m: 8'hC3, seq_l: 8'hC3, par: 1'b0};
    vecs[4] = '{word: 8'h03, seq_m: 8'h03, seq_l: 8'hC0, par: 1'b0};
    vecs[5] = '{word: 8'hFF, seq_m: 8'hFF, seq_l: 8'hFF, par: 1'b0};
    vecs[6] = '{word: 8'h00, seq_m: 8'h00, seq_l: 8'h00, par: 1'b0};
    vecs[7] = '{word: 8'h96, seq_m: 8'h96, seq_l: 8'h69, par: 1'b0};
    vecs[8] = '{word: 8'h1E, seq_m: 8'h1E, seq_l: 8'h78, par: 1'b0};
    vecs[9] = '{word: 8'h80, seq_m: 8'h80, seq_l: 8'h01, par: 1'b1};

    reset      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hA5;
    @(negedge clk);
    @(negedge clk);
    chk("rst_x",     m_x,     1'b0);
    chk("rst_valid", m_v,     1'b0);
    chk("rst_busy",  m_busy,  1'b0);
    chk("rst_done",  m_fd,    1'b0);
    chk("rst_ready", m_ready, 1'b0);
    load_valid = 1'b0;
    reset      = 1'b1;
    step();
    step();

    // Single frames from the vector table
    for (int i = 0; i < 10; i++) begin
      wait_idle();
      load_data  = vecs[i].word;
      load_valid = 1'b1;
      wait_accept("tbl_accept");
      load_valid = 1'b0;
      start = cyc;
      repeat (FLEN - 1) step();
      chk("tbl_seq_msb",  grab_m(start), vecs[i].seq_m);
      chk("tbl_seq_lsb",  grab_l(start), vecs[i].seq_l);
      chk("tbl_fd_last",  obs_fd[start+int'(FLEN)-1], 1'b1);
      chk("tbl_fd_early", obs_fd[start+int'(FLEN)-2], 1'b0);
`ifdef SER_PARITY_EN
      chk("tbl_parity",   obs_x[start+int'(W)], vecs[i].par);
`endif
      step();
      chk("tbl_idle_after", m_v, 1'b0);
    end

    // Back-to-back: FF then 00 offered while the first frame is still running
    wait_idle();
    load_data  = 8'hFF;
    load_valid = 1'b1;
    wait_accept("b2b_acc1");
    start = cyc;
    load_data = 8'h00;
    wait_accept("b2b_acc2");
    chk("b2b_acc_cycle", cyc - start, FLEN);
    load_valid = 1'b0;
    repeat (FLEN - 1) step();
    cnt_v  = 0;
    cnt_fd = 0;
    for (int k = 0; k < 2 * int'(FLEN); k++) begin
      cnt_v  += int'(obs_v[start+k]);
      cnt_fd += int'(obs_fd[start+k]);
    end
    two = {grab_m(start), grab_m(start + int'(FLEN))};
    chk("b2b_contig", cnt_v, 2 * FLEN);
    chk("b2b_bits", two, 16'hFF00);
    chk("b2b_fd_count", cnt_fd, 2);
    chk("b2b_fd1", obs_fd[start+int'(FLEN)-1], 1'b1);
    chk("b2b_fd2", obs_fd[start+2*int'(FLEN)-1], 1'b1);
    step();
    chk("b2b_idle_after", m_v, 1'b0);

    // Word offered mid-frame must wait for ready and then go out intact
    wait_idle();
    load_data  = 8'hA5;
    load_valid = 1'b1;
    wait_accept("mid_acc1");
    start = cyc;
    load_valid = 1'b0;
    repeat (3) step();
    load_data  = 8'h5A;
    load_valid = 1'b1;
    wait_accept("mid_acc2");
    chk("mid_acc_cycle", cyc - start, FLEN);
    start = cyc;
    load_valid = 1'b0;
    repeat (FLEN - 1) step();
    chk("mid_word_msb", grab_m(start), 8'h5A);
    chk("mid_word_lsb", grab_l(start), 8'h5A);

    // Reset at bit 3 of C3 abandons the frame at once
    wait_idle();
    load_data  = 8'hC3;
    load_valid = 1'b1;
    wait_accept("rst_mid_acc");
    load_valid = 1'b0;
    repeat (3) step();
    chk("rst_mid_pre_valid", m_v, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_mid_x",     m_x,     1'b0);
    chk("rst_mid_valid", m_v,     1'b0);
    chk("rst_mid_busy",  m_busy,  1'b0);
    chk("rst_mid_ready", m_ready, 1'b0);
    chk("rst_mid_done",  m_fd,    1'b0);
    q_m.delete();
    q_l.delete();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_rel_ready", m_ready, 1'b1);
    repeat (FLEN + 2) step();

    // Random traffic against the model
    load_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!load_valid || last_acc) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = W'($urandom);
      end
      step();
    end
    load_valid = 1'b0;
    repeat (FLEN + 2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
